// File: rtl/nes_joypad_port.sv
// ---------------------------------------------------------------------------
// nes_joypad_port
//
// CPU-side controller port for both NES joypads ($4016 / $4017). Takes the
// pressed-button vectors from the PS/2 scanner, adds turbo autofire for the
// TA/TB buttons, and serialises one button bit per CPU read in standard NES
// order (A, B, Select, Start, Up, Down, Left, Right).
//
// Parameters
//   TURBO_DIV     i_clk cycles per turbo half-period (1..65535)
//
// Ports
//   i_clk         system clock; CPU strobes are synchronous to it
//   i_rstn        asynchronous active-low reset
//   i_jp1_vector  pad 1 held buttons {up,down,left,right,b,a,tb,ta,select,start}
//   i_jp2_vector  pad 2 held buttons, same encoding
//   i_cpu_addr    CPU address (full 16-bit decode, no mirrors)
//   i_cpu_wr      one-cycle write strobe
//   i_cpu_rd      one-cycle read strobe
//   i_cpu_wdata   CPU write data (bit 0 drives the latch strobe)
//   o_cpu_rdata   registered read data
//   o_rdata_val   high for one cycle when o_cpu_rdata belongs to this block
// ---------------------------------------------------------------------------
module nes_joypad_port #(
    parameter logic [15:0] TURBO_DIV = 16'd50000
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [9:0]  i_jp1_vector,
    input  logic [9:0]  i_jp2_vector,
    input  logic [15:0] i_cpu_addr,
    input  logic        i_cpu_wr,
    input  logic        i_cpu_rd,
    input  logic [7:0]  i_cpu_wdata,
    output logic [7:0]  o_cpu_rdata,
    output logic        o_rdata_val
);

    // Button positions inside the scanner vectors.
    localparam int unsigned BTN_START  = 0;
    localparam int unsigned BTN_SELECT = 1;
    localparam int unsigned BTN_TA     = 2;
    localparam int unsigned BTN_TB     = 3;
    localparam int unsigned BTN_A      = 4;
    localparam int unsigned BTN_B      = 5;
    localparam int unsigned BTN_RIGHT  = 6;
    localparam int unsigned BTN_LEFT   = 7;
    localparam int unsigned BTN_DOWN   = 8;
    localparam int unsigned BTN_UP     = 9;

    // Open-bus pattern returned in the upper bits of every read.
    localparam logic [6:0] RD_UPPER = 7'b0100000;

    logic        strobe_q,  strobe_d;
    logic [15:0] turbo_q,   turbo_d;
    logic        phase_q,   phase_d;
    logic [7:0]  sh1_q,     sh1_d;
    logic [7:0]  sh2_q,     sh2_d;
    logic [7:0]  rdata_q,   rdata_d;
    logic        rval_q,    rval_d;

    logic        hit4016, hit4017;
    logic        rd_ok;
    logic [7:0]  byte1, byte2;

    // Map a scanner vector onto the NES shift order, merging turbo into A/B.
    function automatic logic [7:0] nes_byte(input logic [9:0] v, input logic phase);
        logic a_eff;
        logic b_eff;
        a_eff = v[BTN_A] | (v[BTN_TA] & phase);
        b_eff = v[BTN_B] | (v[BTN_TB] & phase);
        return {v[BTN_RIGHT], v[BTN_LEFT], v[BTN_DOWN], v[BTN_UP],
                v[BTN_START], v[BTN_SELECT], b_eff, a_eff};
    endfunction

    assign hit4016 = (i_cpu_addr == 16'h4016);
    assign hit4017 = (i_cpu_addr == 16'h4017);
    // A write in the same cycle wins; the read is dropped entirely.
    assign rd_ok   = i_cpu_rd & ~i_cpu_wr;

    assign byte1 = nes_byte(i_jp1_vector, phase_q);
    assign byte2 = nes_byte(i_jp2_vector, phase_q);

    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        strobe_d = strobe_q;
        turbo_d  = turbo_q + 16'd1;
        phase_d  = phase_q;
        sh1_d    = sh1_q;
        sh2_d    = sh2_q;
        rdata_d  = rdata_q;
        rval_d   = 1'b0;

        if (i_cpu_wr && hit4016) begin
            strobe_d = i_cpu_wdata[0];
        end

        if (turbo_q == TURBO_DIV - 16'd1) begin
            turbo_d = 16'd0;
            phase_d = ~phase_q;
        end

        // Strobe high: continuous reload, reads see the live A button.
        // Strobe low: frozen, each read shifts in a 1 from the top.
        if (strobe_q) begin
            sh1_d = byte1;
            sh2_d = byte2;
        end else begin
            if (rd_ok && hit4016) sh1_d = {1'b1, sh1_q[7:1]};
            if (rd_ok && hit4017) sh2_d = {1'b1, sh2_q[7:1]};
        end

        if (rd_ok && hit4016) begin
            rval_d  = 1'b1;
            rdata_d = {RD_UPPER, strobe_q ? byte1[0] : sh1_q[0]};
        end else if (rd_ok && hit4017) begin
            rval_d  = 1'b1;
            rdata_d = {RD_UPPER, strobe_q ? byte2[0] : sh2_q[0]};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its next-state value from the same clock edge. The shift
    // registers are plain flops, so resetting them is cheap and gives
    // deterministic reads before the first strobe.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            strobe_q <= 1'b0;
            turbo_q  <= 16'd0;
            phase_q  <= 1'b0;
            sh1_q    <= 8'h00;
            sh2_q    <= 8'h00;
            rdata_q  <= 8'h00;
            rval_q   <= 1'b0;
        end else begin
            strobe_q <= strobe_d;
            turbo_q  <= turbo_d;
            phase_q  <= phase_d;
            sh1_q    <= sh1_d;
            sh2_q    <= sh2_d;
            rdata_q  <= rdata_d;
            rval_q   <= rval_d;
        end
    end

    assign o_cpu_rdata = rdata_q;
    assign o_rdata_val = rval_q;

endmodule

// File: tb/tb_nes_joypad_port.sv
// ---------------------------------------------------------------------------
// tb_nes_joypad_port
//
// Self-checking bench for nes_joypad_port. Directed scenarios followed by a
// randomized run; every expected value comes from a behavioural model of the
// controller port (button order, strobe latching, turbo timing by elapsed
// cycle count).
// ---------------------------------------------------------------------------
module tb_nes_joypad_port;

    localparam int TB_DIV = 4;

    logic        clk;
    logic        rstn;
    logic [9:0]  jp1;
    logic [9:0]  jp2;
    logic [15:0] cpu_addr;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        rdata_val;

    int checks   = 0;
    int failures = 0;

    // Model state.
    int         cyc;           // clock edges since reset release
    logic       m_strobe;
    logic [7:0] m_sh1;
    logic [7:0] m_sh2;
    logic [7:0] m_last;

    nes_joypad_port #(.TURBO_DIV(16'(TB_DIV))) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_jp1_vector (jp1),
        .i_jp2_vector (jp2),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_wr     (cpu_wr),
        .i_cpu_rd     (cpu_rd),
        .i_cpu_wdata  (cpu_wdata),
        .o_cpu_rdata  (cpu_rdata),
        .o_rdata_val  (rdata_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Turbo phase is high during the second half of every 2*TB_DIV window.
    function automatic logic phase_now();
        return ((cyc / TB_DIV) % 2) == 1;
    endfunction

    // Serial byte a pad presents, from the named buttons.
    function automatic logic [7:0] pad_byte(input logic [9:0] v);
        logic start, select, ta, tb, a, b, right, left, down, up;
        logic [7:0] r;
        {up, down, left, right, b, a, tb, ta, select, start} = v;
        r    = 8'h00;
        r[0] = a | (ta & phase_now());
        r[1] = b | (tb & phase_now());
        r[2] = select;
        r[3] = start;
        r[4] = up;
        r[5] = down;
        r[6] = left;
        r[7] = right;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_strobe = 1'b0;
        m_sh1    = 8'h00;
        m_sh2    = 8'h00;
        m_last   = 8'h00;
    endtask

    // All bus tasks start and end on a falling edge, so consecutive calls
    // issue accesses on consecutive cycles.
    task automatic do_read(input logic [15:0] addr, input string tag);
        logic [7:0] exp_data;
        logic       exp_val;
        logic [7:0] live;
        exp_val  = 1'b0;
        exp_data = m_last;
        if (addr == 16'h4016) begin
            live     = pad_byte(jp1);
            exp_val  = 1'b1;
            exp_data = 8'h40 | {7'd0, m_strobe ? live[0] : m_sh1[0]};
            if (!m_strobe) m_sh1 = {1'b1, m_sh1[7:1]};
        end else if (addr == 16'h4017) begin
            live     = pad_byte(jp2);
            exp_val  = 1'b1;
            exp_data = 8'h40 | {7'd0, m_strobe ? live[0] : m_sh2[0]};
            if (!m_strobe) m_sh2 = {1'b1, m_sh2[7:1]};
        end
        m_last   = exp_data;
        cpu_addr = addr;
        cpu_rd   = 1'b1;
        @(negedge clk);
        cpu_rd   = 1'b0;
        chk({tag, "_val"}, {7'd0, rdata_val}, {7'd0, exp_val});
        chk({tag, "_data"}, cpu_rdata, exp_data);
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [7:0] data,
                            input logic with_rd, input string tag);
        if (addr == 16'h4016) begin
            // The registers hold whatever was loaded in the write cycle.
            if (m_strobe) begin
                m_sh1 = pad_byte(jp1);
                m_sh2 = pad_byte(jp2);
            end
            m_strobe = data[0];
        end
        cpu_addr  = addr;
        cpu_wdata = data;
        cpu_wr    = 1'b1;
        cpu_rd    = with_rd;
        @(negedge clk);
        cpu_wr    = 1'b0;
        cpu_rd    = 1'b0;
        if (with_rd) begin
            chk({tag, "_coll_val"}, {7'd0, rdata_val}, 8'd0);
            chk({tag, "_coll_data"}, cpu_rdata, m_last);
        end
    endtask

    task automatic do_idle(input string tag);
        @(negedge clk);
        chk({tag, "_idle_val"}, {7'd0, rdata_val}, 8'd0);
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b0;
        #1;
        chk({tag, "_rst_data"}, cpu_rdata, 8'h00);
        chk({tag, "_rst_val"}, {7'd0, rdata_val}, 8'd0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn      = 1'b0;
        jp1       = '0;
        jp2       = '0;
        cpu_addr  = '0;
        cpu_wr    = 1'b0;
        cpu_rd    = 1'b0;
        cpu_wdata = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_data", cpu_rdata, 8'h00);
        chk("reset_val", {7'd0, rdata_val}, 8'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Latch and read pad 1: a + start.
        jp1 = 10'b0000010001;
        do_write(16'h4016, 8'h01, 1'b0, "latch1_hi");
        do_write(16'h4016, 8'h00, 1'b0, "latch1_lo");
        for (int i = 0; i < 10; i++) do_read(16'h4016, $sformatf("pad1_rd%0d", i));
        do_idle("pad1");

        // Pad independence: pad 2 = right only, interleaved pad 1 reads.
        jp2 = 10'b0001000000;
        do_write(16'h4016, 8'h01, 1'b0, "latch2_hi");
        do_write(16'h4016, 8'h00, 1'b0, "latch2_lo");
        for (int i = 0; i < 7; i++) begin
            do_read(16'h4017, $sformatf("pad2_rd%0d", i));
            do_read(16'h4016, $sformatf("pad2_p1_%0d", i));
        end
        do_read(16'h4017, "pad2_rd7");
        do_read(16'h4017, "pad2_rd8");
        do_write(16'h4017, 8'h01, 1'b0, "wr4017_ignored");
        do_read(16'h4017, "pad2_after_4017wr");

        // Strobe held high: reads follow live A and never advance.
        do_write(16'h4016, 8'h01, 1'b0, "live_hi");
        for (int i = 0; i < 6; i++) begin
            jp1 = (i % 2 == 0) ? 10'b0000100000 : 10'b0000110000;
            do_read(16'h4016, $sformatf("live_rd%0d", i));
        end
        do_write(16'h4016, 8'h00, 1'b0, "live_lo");

        // Turbo: ta only, strobe high, reads on consecutive cycles.
        do_reset("turbo");
        jp1 = 10'b0000000100;
        do_write(16'h4016, 8'h01, 1'b0, "turbo_hi");
        for (int i = 0; i < 18; i++) do_read(16'h4016, $sformatf("turbo_rd%0d", i));
        do_write(16'h4016, 8'h00, 1'b0, "turbo_lo");

        // Collision and decode.
        jp1 = 10'b0000010001;
        do_write(16'h4016, 8'h01, 1'b0, "coll_hi");
        do_write(16'h4016, 8'h00, 1'b0, "coll_lo");
        do_read(16'h4016, "coll_rd0");
        do_write(16'h4016, 8'h00, 1'b1, "coll_4016");
        do_write(16'h4017, 8'h00, 1'b1, "coll_4017");
        do_read(16'h4018, "dec_4018");
        do_read(16'h6016, "dec_6016");
        do_read(16'h0016, "dec_0016");
        for (int i = 1; i < 4; i++) do_read(16'h4016, $sformatf("coll_rd%0d", i));

        // Reset in the middle of a read sequence.
        jp1 = 10'b1111111111;
        do_write(16'h4016, 8'h01, 1'b0, "mid_hi");
        do_write(16'h4016, 8'h00, 1'b0, "mid_lo");
        for (int i = 0; i < 3; i++) do_read(16'h4016, $sformatf("mid_pre%0d", i));
        do_reset("mid");
        for (int i = 0; i < 9; i++) do_read(16'h4016, $sformatf("mid_post%0d", i));

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            int op;
            jp1 = 10'($urandom);
            jp2 = 10'($urandom);
            op  = int'($urandom_range(0, 9));
            case (op)
                0, 1:    do_read(16'h4016, "rnd_rd1");
                2, 3:    do_read(16'h4017, "rnd_rd2");
                4:       do_write(16'h4016, 8'($urandom), 1'b0, "rnd_wr");
                5:       do_write(16'h4016, 8'h00, 1'b0, "rnd_wr0");
                6:       do_read(($urandom_range(0, 1) == 0) ? 16'h4018 : 16'h5016, "rnd_miss");
                7:       do_write(($urandom_range(0, 1) == 0) ? 16'h4016 : 16'h4017,
                                  8'($urandom), 1'b1, "rnd_coll");
                8:       do_idle("rnd");
                default: do_write(16'h4016, 8'h01, 1'b0, "rnd_wr1");
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Backstop so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
